// File: rtl/mux_sel_sequencer.sv
// Parallel-to-serial front end for an 8:1 mux tree: holds a word on the mux bus and walks the select.
// Optional macro MUX_SEQ_PARITY_EN appends an even-parity bit after the eight data bits.
module mux_sel_sequencer #(
  parameter int DIV       = 1,
  parameter int MSB_FIRST = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] mux_a_o,
  output logic [2:0] mux_sel_o,
  input  logic       mux_out_i,
  output logic       ser_o,
  output logic       ser_valid_o,
  output logic       ser_last_o,
  output logic       busy_o
);

  if (DIV < 1 || DIV > 255) begin : g_div_check
    $error("mux_sel_sequencer: DIV must be in 1..255");
  end

  localparam logic [2:0] SEL_FIRST = (MSB_FIRST != 0) ? 3'd7 : 3'd0;
  localparam logic [2:0] SEL_LAST  = (MSB_FIRST != 0) ? 3'd0 : 3'd7;
  localparam logic [7:0] DIV_LAST  = 8'(DIV - 1);

  typedef enum logic [1:0] {
`ifdef MUX_SEQ_PARITY_EN
    PAR,
`endif
    IDLE,
    SHIFT
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] div_cnt_q, div_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] mux_a_q, mux_a_d;
  logic [2:0] sel_q, sel_d;
  logic       ser_q, ser_d;
  logic       ser_vld_q, ser_vld_d;
  logic       ser_last_q, ser_last_d;
`ifdef MUX_SEQ_PARITY_EN
  logic       par_q, par_d;
`endif

  logic       tick;
  logic [2:0] sel_step;

  assign tick     = (div_cnt_q == DIV_LAST);
  assign sel_step = (MSB_FIRST != 0) ? (sel_q - 3'd1) : (sel_q + 3'd1);

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    mux_a_d    = mux_a_q;
    sel_d      = sel_q;
    ser_d      = ser_q;
    ser_vld_d  = 1'b0;
    ser_last_d = 1'b0;
`ifdef MUX_SEQ_PARITY_EN
    par_d      = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mux_a_d   = in_data;
          sel_d     = SEL_FIRST;
          div_cnt_d = 8'd0;
          bit_cnt_d = 3'd0;
`ifdef MUX_SEQ_PARITY_EN
          par_d     = 1'b0;
`endif
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          ser_d     = mux_out_i;
          ser_vld_d = 1'b1;
          div_cnt_d = 8'd0;
          bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef MUX_SEQ_PARITY_EN
          par_d     = par_q ^ mux_out_i;
`endif
          // The select parks on the last index instead of wrapping while busy.
          if (sel_q != SEL_LAST) sel_d = sel_step;
          if (bit_cnt_q == 3'd7) begin
`ifdef MUX_SEQ_PARITY_EN
            state_d    = PAR;
`else
            ser_last_d = 1'b1;
            sel_d      = SEL_FIRST;
            state_d    = IDLE;
`endif
          end
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end
`ifdef MUX_SEQ_PARITY_EN
      PAR: begin
        if (tick) begin
          ser_d      = par_q;
          ser_vld_d  = 1'b1;
          ser_last_d = 1'b1;
          div_cnt_d  = 8'd0;
          sel_d      = SEL_FIRST;
          state_d    = IDLE;
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      div_cnt_q  <= 8'd0;
      bit_cnt_q  <= 3'd0;
      mux_a_q    <= 8'd0;
      sel_q      <= SEL_FIRST;
      ser_q      <= 1'b0;
      ser_vld_q  <= 1'b0;
      ser_last_q <= 1'b0;
`ifdef MUX_SEQ_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      mux_a_q    <= mux_a_d;
      sel_q      <= sel_d;
      ser_q      <= ser_d;
      ser_vld_q  <= ser_vld_d;
      ser_last_q <= ser_last_d;
`ifdef MUX_SEQ_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign mux_a_o     = mux_a_q;
  assign mux_sel_o   = sel_q;
  assign ser_o       = ser_q;
  assign ser_valid_o = ser_vld_q;
  assign ser_last_o  = ser_last_q;

endmodule
